// File: rtl/otter_bp_pkg.sv
// Shared types and constants for the OTTER branch target buffer.
// The table entry layout follows the BP_* widths, and the predictor's parameters default to them.
package otter_bp_pkg;

  localparam int BP_XLEN  = 32;
  localparam int BP_TAG_W = 8;
  localparam int BP_CTR_W = 2;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_CTR_W-1:0] ctr;
    logic                is_jump;
    logic [BP_XLEN-1:0]  target;
  } bp_entry_t;

  // Weakly-taken value, the first state whose MSB predicts taken.
  function automatic logic [31:0] CTR_WEAK_TAKEN(input int w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] CTR_MAX(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating counter next-state logic: set_max wins over inc, and inc wins over dec.
// The logic is purely combinational (zero latency) and has no flow control.
module bp_sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  logic         inc,
  input  logic         dec,
  input  logic         set_max,
  output logic [W-1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (set_max) begin
      cnt_next = '1;
    end else if (inc) begin
      if (cnt != '1) cnt_next = cnt + W'(1);
    end else if (dec) begin
      if (cnt != '0) cnt_next = cnt - W'(1);
    end
  end

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters. Lookup is combinational, and writes become visible the next cycle.
// The predictor never stalls EX. Updates that arrive during a clear sweep are dropped, but the perf counters still count them.
module otter_branch_predictor
  import otter_bp_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = BP_TAG_W,
  parameter int CTR_W   = BP_CTR_W
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [XLEN-1:0] LKP_PC,
  output logic            PRED_HIT,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_TARGET,
  output logic            READY,
  input  logic            UPD_VALID,
  input  logic [XLEN-1:0] UPD_PC,
  input  logic            UPD_IS_BR,
  input  logic            UPD_IS_JUMP,
  input  logic            UPD_TAKEN,
  input  logic [XLEN-1:0] UPD_TARGET,
  input  logic            UPD_MISPRED,
  input  logic            FLUSH_ALL,
  output logic [31:0]     UPD_COUNT,
  output logic [31:0]     MISS_COUNT
);

  localparam int               IDX_W   = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(CTR_WEAK_TAKEN(CTR_W));
  localparam logic [CTR_W-1:0] CTR_TOP = CTR_W'(CTR_MAX(CTR_W));

  bp_state_t        state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic [31:0]      upd_count_q, upd_count_d;
  logic [31:0]      miss_count_q, miss_count_d;

  bp_entry_t        tbl_q [ENTRIES];
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_widx;
  bp_entry_t        tbl_wdat;

  logic             ready;
  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  bp_entry_t        upd_ent;
  logic             upd_en, upd_hit, upd_jump, upd_taken;
  logic [CTR_W-1:0] upd_ctr_next;
  logic             unused_pc_bits;

  assign ready          = (state_q == BP_RUN);
  assign READY          = ready;
  assign lkp_idx        = LKP_PC[IDX_W+1:2];
  assign lkp_tag        = LKP_PC[IDX_W+2+TAG_W-1:IDX_W+2];
  assign upd_idx        = UPD_PC[IDX_W+1:2];
  assign upd_tag        = UPD_PC[IDX_W+2+TAG_W-1:IDX_W+2];
  assign unused_pc_bits = ^{LKP_PC, UPD_PC};

  always_comb begin
    PRED_HIT    = ready & tbl_q[lkp_idx].valid & (tbl_q[lkp_idx].tag == BP_TAG_W'(lkp_tag));
    PRED_TAKEN  = PRED_HIT & (tbl_q[lkp_idx].is_jump | tbl_q[lkp_idx].ctr[CTR_W-1]);
    PRED_TARGET = PRED_TAKEN ? XLEN'(tbl_q[lkp_idx].target) : LKP_PC + XLEN'(4);
  end

  // A jump marked as a branch as well is still handled as a jump, and a jump is always taken.
  assign upd_en    = UPD_VALID & (UPD_IS_BR | UPD_IS_JUMP);
  assign upd_jump  = UPD_IS_JUMP;
  assign upd_taken = UPD_TAKEN | UPD_IS_JUMP;
  assign upd_ent   = tbl_q[upd_idx];
  assign upd_hit   = upd_ent.valid & (upd_ent.tag == BP_TAG_W'(upd_tag));

  bp_sat_counter #(.W(CTR_W)) u_dir_ctr (
    .cnt      (CTR_W'(upd_ent.ctr)),
    .inc      (upd_taken),
    .dec      (~upd_taken),
    .set_max  (upd_jump),
    .cnt_next (upd_ctr_next)
  );

  bp_sat_counter #(.W(32)) u_upd_cnt (
    .cnt      (upd_count_q),
    .inc      (upd_en),
    .dec      (1'b0),
    .set_max  (1'b0),
    .cnt_next (upd_count_d)
  );

  bp_sat_counter #(.W(32)) u_miss_cnt (
    .cnt      (miss_count_q),
    .inc      (upd_en & UPD_MISPRED),
    .dec      (1'b0),
    .set_max  (1'b0),
    .cnt_next (miss_count_d)
  );

  // The sweep and the EX update share the single write port, and FLUSH_ALL silences both.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    tbl_we      = 1'b0;
    tbl_widx    = upd_idx;
    tbl_wdat    = upd_ent;
    if (FLUSH_ALL) begin
      state_d     = BP_INIT;
      sweep_idx_d = '0;
    end else if (state_q == BP_INIT) begin
      tbl_we   = 1'b1;
      tbl_widx = sweep_idx_q;
      tbl_wdat = '0;
      if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
        state_d = BP_RUN;
      end else begin
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        tbl_we       = 1'b1;
        tbl_wdat.ctr = BP_CTR_W'(upd_ctr_next);
        if (upd_jump) tbl_wdat.is_jump = 1'b1;
        if (upd_taken) tbl_wdat.target = BP_XLEN'(UPD_TARGET);
      end else if (upd_taken) begin
        tbl_we           = 1'b1;
        tbl_wdat.valid   = 1'b1;
        tbl_wdat.tag     = BP_TAG_W'(upd_tag);
        tbl_wdat.ctr     = BP_CTR_W'(upd_jump ? CTR_TOP : CTR_WT);
        tbl_wdat.is_jump = upd_jump;
        tbl_wdat.target  = BP_XLEN'(UPD_TARGET);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= BP_INIT;
      sweep_idx_q  <= '0;
      upd_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_idx_q  <= sweep_idx_d;
      upd_count_q  <= upd_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Only the valid bit needs clearing, and the sweep takes care of that after reset.
  always_ff @(posedge CLK) begin
    if (RESET_N && tbl_we) tbl_q[tbl_widx] <= tbl_wdat;
  end

  assign UPD_COUNT  = upd_count_q;
  assign MISS_COUNT = miss_count_q;

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Table-driven bench for otter_branch_predictor with a lookup scoreboard.
// It includes hand-written sequences for reset, flush, same-cycle lookup and counter saturation.
module tb_otter_branch_predictor;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] LKP_PC;
  logic        PRED_HIT, PRED_TAKEN, READY;
  logic [31:0] PRED_TARGET;
  logic        UPD_VALID, UPD_IS_BR, UPD_IS_JUMP, UPD_TAKEN, UPD_MISPRED, FLUSH_ALL;
  logic [31:0] UPD_PC, UPD_TARGET;
  logic [31:0] UPD_COUNT, MISS_COUNT;

  always #5 CLK = ~CLK;

  otter_branch_predictor dut (
    .CLK(CLK), .RESET_N(RESET_N), .LKP_PC(LKP_PC),
    .PRED_HIT(PRED_HIT), .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET), .READY(READY),
    .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC), .UPD_IS_BR(UPD_IS_BR), .UPD_IS_JUMP(UPD_IS_JUMP),
    .UPD_TAKEN(UPD_TAKEN), .UPD_TARGET(UPD_TARGET), .UPD_MISPRED(UPD_MISPRED),
    .FLUSH_ALL(FLUSH_ALL), .UPD_COUNT(UPD_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  // ctl = {upd_valid, is_br, is_jump, taken, mispred}; e_ht = {hit, taken}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic [31:0] lkp;
    logic [1:0]  e_ht;
    logic [31:0] e_tgt;
  } vec_t;

  typedef struct {
    string       nm;
    logic        hit;
    logic        tkn;
    logic [31:0] tgt;
  } exp_t;

  vec_t        vecs [20];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] n_upd = 0;
  logic [31:0] n_miss = 0;
  int          cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_lkp(input string nm, input logic hit, input logic tkn, input logic [31:0] tgt);
    exp_t e;
    e.nm = nm; e.hit = hit; e.tkn = tkn; e.tgt = tgt;
    sb.push_back(e);
  endtask

  task automatic check_lkp();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_empty: got no expectation want one queued");
    end else begin
      e = sb.pop_front();
      chk({e.nm, "_hit"}, {31'd0, PRED_HIT}, {31'd0, e.hit});
      chk({e.nm, "_taken"}, {31'd0, PRED_TAKEN}, {31'd0, e.tkn});
      chk({e.nm, "_target"}, PRED_TARGET, e.tgt);
    end
  endtask

  task automatic drive_upd(input logic [4:0] ctl, input logic [31:0] pc, input logic [31:0] tgt);
    {UPD_VALID, UPD_IS_BR, UPD_IS_JUMP, UPD_TAKEN, UPD_MISPRED} = ctl;
    UPD_PC = pc;
    UPD_TARGET = tgt;
    if (ctl[4] && (ctl[3] || ctl[2])) begin
      n_upd = sat_inc(n_upd);
      if (ctl[0]) n_miss = sat_inc(n_miss);
    end
  endtask

  task automatic lookup(input string nm, input logic [31:0] pc, input logic hit, input logic tkn,
                        input logic [31:0] tgt);
    @(negedge CLK);
    UPD_VALID = 1'b0;
    LKP_PC = pc;
    expect_lkp(nm, hit, tkn, tgt);
    #1 check_lkp();
  endtask

  task automatic run_vec(input vec_t v, input int i);
    @(negedge CLK);
    drive_upd(v.ctl, v.upc, v.utgt);
    lookup($sformatf("vec%0d", i), v.lkp, v.e_ht[1], v.e_ht[0], v.e_tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{5'b00000, 32'h0,   32'h0,   32'h100,        2'b00, 32'h104},
      '{5'b11011, 32'h200, 32'h180, 32'h200,        2'b11, 32'h180},
      '{5'b11001, 32'h200, 32'h0,   32'h200,        2'b10, 32'h204},
      '{5'b11000, 32'h200, 32'h0,   32'h200,        2'b10, 32'h204},
      '{5'b11011, 32'h200, 32'h180, 32'h200,        2'b10, 32'h204},
      '{5'b11011, 32'h200, 32'h180, 32'h200,        2'b11, 32'h180},
      '{5'b11010, 32'h200, 32'h180, 32'h200,        2'b11, 32'h180},
      '{5'b11010, 32'h200, 32'h180, 32'h200,        2'b11, 32'h180},
      '{5'b11001, 32'h200, 32'hABC, 32'h200,        2'b11, 32'h180},
      '{5'b11001, 32'h200, 32'h0,   32'h200,        2'b10, 32'h204},
      '{5'b11011, 32'h200, 32'h1C0, 32'h200,        2'b11, 32'h1C0},
      '{5'b10111, 32'h300, 32'h080, 32'h200,        2'b00, 32'h204},
      '{5'b00000, 32'h0,   32'h0,   32'h300,        2'b11, 32'h080},
      '{5'b11000, 32'h300, 32'h0,   32'h300,        2'b11, 32'h080},
      '{5'b11000, 32'h300, 32'h0,   32'h300,        2'b11, 32'h080},
      '{5'b11000, 32'h300, 32'h0,   32'h300,        2'b11, 32'h080},
      '{5'b11000, 32'h404, 32'h0,   32'h404,        2'b00, 32'h408},
      '{5'b11101, 32'h408, 32'h040, 32'h408,        2'b11, 32'h040},
      '{5'b10011, 32'h40C, 32'h050, 32'h40C,        2'b00, 32'h410},
      '{5'b00000, 32'h0,   32'h0,   32'hFFFF_FFFC,  2'b00, 32'h0}
    };

    RESET_N = 1'b0; LKP_PC = 32'h100; FLUSH_ALL = 1'b0;
    UPD_VALID = 1'b0; UPD_IS_BR = 1'b0; UPD_IS_JUMP = 1'b0; UPD_TAKEN = 1'b0;
    UPD_MISPRED = 1'b0; UPD_PC = 32'h0; UPD_TARGET = 32'h0;

    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_ready", {31'd0, READY}, 32'd0);
    chk("rst_hit", {31'd0, PRED_HIT}, 32'd0);
    chk("rst_taken", {31'd0, PRED_TAKEN}, 32'd0);
    chk("rst_target", PRED_TARGET, 32'h104);
    chk("rst_upd_count", UPD_COUNT, 32'd0);
    chk("rst_miss_count", MISS_COUNT, 32'd0);
    RESET_N = 1'b1;
    cnt = 0;
    while (!READY && cnt < 200) begin
      cnt++;
      @(negedge CLK); #1;
    end
    chk("init_ready_cycles", cnt, 32'd64);
    chk("init_upd_count", UPD_COUNT, 32'd0);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);
    chk("table_upd_count", UPD_COUNT, n_upd);
    chk("table_miss_count", MISS_COUNT, n_miss);

    // A lookup in the same cycle as the allocating write still sees the old entry.
    @(negedge CLK);
    drive_upd(5'b11010, 32'h604, 32'h700);
    LKP_PC = 32'h604;
    expect_lkp("same_cycle", 1'b0, 1'b0, 32'h608);
    #1 check_lkp();
    lookup("after_alloc", 32'h604, 1'b1, 1'b1, 32'h700);

    // FLUSH_ALL wins over the concurrent update, and the counters keep counting.
    @(negedge CLK);
    FLUSH_ALL = 1'b1;
    drive_upd(5'b11011, 32'h500, 32'h123);
    @(negedge CLK);
    FLUSH_ALL = 1'b0;
    UPD_VALID = 1'b0;
    #1;
    chk("flush_upd_count", UPD_COUNT, n_upd);
    chk("flush_miss_count", MISS_COUNT, n_miss);
    cnt = 0;
    while (!READY && cnt < 200) begin
      if (cnt == 5) drive_upd(5'b11010, 32'h704, 32'h777);
      else UPD_VALID = 1'b0;
      cnt++;
      @(negedge CLK); #1;
    end
    UPD_VALID = 1'b0;
    chk("flush_ready_cycles", cnt, 32'd64);
    lookup("flush_500", 32'h500, 1'b0, 1'b0, 32'h504);
    lookup("sweep_704", 32'h704, 1'b0, 1'b0, 32'h708);
    lookup("flush_604", 32'h604, 1'b0, 1'b0, 32'h608);
    chk("sweep_upd_count", UPD_COUNT, n_upd);

    // Preload the miss counter just below saturation.
    @(negedge CLK);
    force dut.miss_count_q = 32'hFFFF_FFFE;
    @(negedge CLK);
    release dut.miss_count_q;
    n_miss = 32'hFFFF_FFFE;
    #1 chk("miss_preload", MISS_COUNT, n_miss);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      drive_upd(5'b11001, 32'h800, 32'h0);
      @(negedge CLK);
      UPD_VALID = 1'b0;
      #1 chk($sformatf("miss_sat%0d", k), MISS_COUNT, 32'hFFFF_FFFF);
    end
    chk("sat_upd_count", UPD_COUNT, n_upd);

    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    #1;
    chk("rerst_upd_count", UPD_COUNT, 32'd0);
    chk("rerst_miss_count", MISS_COUNT, 32'd0);
    chk("rerst_ready", {31'd0, READY}, 32'd0);
    RESET_N = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
